end_screen_draw: RTL
====================

END_SCREEN_DRAW -- requirements
Module: end_screen_draw

Interface
REQ-001 SCREEN_W, default 160, screen width in pixels.
REQ-002 SCREEN_H, default 120, screen height in pixels.
REQ-003 BANNER_X0 / BANNER_X1, defaults 40 / 119, inclusive banner column bounds.
REQ-004 BANNER_Y0 / BANNER_Y1, defaults 50 / 69, inclusive banner row bounds.
REQ-005 clk  in  1  system clock (CLOCK_50 domain); the block uses one clock.
REQ-006 resetn  in  1  reset, asynchronous and active-low.
REQ-007 win_in  in  1  level from the win checker, high once all bricks are cleared.
REQ-008 loss_in  in  1  level from the lose checker, high once lives are exhausted.
REQ-009 x  out  10  pixel column to the draw mux win/lose path.
REQ-010 y  out  10  pixel row to the draw mux win/lose path.
REQ-011 colour  out  3  pixel colour.
REQ-012 writeEn  out  1  plot strobe; x, y and colour are valid in the same cycle.
REQ-013 win_draw  out  1  draw mux win select; high while drawing after a win.
REQ-014 lose_draw  out  1  draw mux lose select; high while drawing after a loss.
REQ-015 done  out  1  high once the end screen is complete.

Function
REQ-016 States: IDLE, FILL, BANNER, DONE.
REQ-017 Event detection: win_in and loss_in edges detected against registered previous values, which reset to 0; a level already high at reset release counts as an edge.
REQ-018 IDLE->FILL on the clock after a detected edge; the result is latched at the transition; loss wins if both edges occur in the same cycle.
REQ-019 Edges outside IDLE are ignored; the latched result never changes before reset.
REQ-020 FILL: one pixel per cycle, raster order, x fastest, (0,0) to (SCREEN_W-1,SCREEN_H-1); colour BLACK 3'b000; 19200 cycles at defaults.
REQ-021 FILL->BANNER on the cycle after pixel (SCREEN_W-1,SCREEN_H-1) is written; the first BANNER pixel is (BANNER_X0,BANNER_Y0), with no gap cycle.
REQ-022 BANNER: raster over the banner bounds, one pixel per cycle, 1600 cycles at defaults; colour GREEN 3'b010 on win, RED 3'b100 on loss.
REQ-023 BANNER->DONE on the cycle after pixel (BANNER_X1,BANNER_Y1) is written; DONE is terminal until reset.
REQ-024 writeEn = 1 exactly in FILL and BANNER; 0 in IDLE and DONE.
REQ-025 win_draw / lose_draw: high in FILL, BANNER and DONE per the latched result; never both high.
REQ-026 done = 1 only in DONE.
REQ-027 x/y counters are 10-bit; column wraps to the start column and the row increments only at the row-end column; no counter exceeds its bound.
REQ-028 First pixel latency: the edge is sampled at clock N, and (0,0) with writeEn=1 is presented after clock N+1.

Reset
REQ-029 Reset asserted: state=IDLE, x=0, y=0, colour=0, writeEn=0, win_draw=0, lose_draw=0, done=0, latched result and edge registers cleared, immediately and regardless of clk.
REQ-030 Reset mid-FILL or mid-BANNER aborts drawing with no further writeEn pulses; after release the block waits in IDLE for a new edge.

Structure
REQ-031 Shared package holds the colour constants BLACK/RED/GREEN, the screen dimensions and the state encoding.
REQ-032 One sub-module, raster_scan (parameterised rectangle bounds, start/step/last outputs), is used for both FILL and BANNER.

Verification
REQ-033 Raise loss_in -> 19200 BLACK writes (0,0)..(159,119), then 1600 RED writes (40,50)..(119,69), then done=1, lose_draw=1, writeEn=0.
REQ-034 Raise win_in -> same sequence with GREEN banner; win_draw=1, lose_draw=0 throughout.
REQ-035 Raise win_in and loss_in in the same cycle -> RED banner, lose_draw=1 only.
REQ-036 Raise win_in, then loss_in 100 cycles later -> no restart; GREEN banner; total writes 20800.
REQ-037 Assert resetn low at FILL pixel 5000 -> all outputs 0 asynchronously; after release there are no writes until a new edge, which restarts at (0,0).
REQ-038 Check pixel transitions (159,0)->(0,1), (159,119)->(40,50) and (119,50)->(40,51) -> each occurs in consecutive cycles with writeEn held high.

Source files
------------

// File: rtl/end_screen_draw_pkg.sv
// Shared constants and types for the end-of-game screen painter:
// coordinate/colour widths, default screen and banner geometry,
// colour codes, FSM state encoding and the pixel payload.
package end_screen_draw_pkg;

  localparam int unsigned COORD_W  = 10;
  localparam int unsigned COLOUR_W = 3;

  localparam int unsigned DEF_SCREEN_W = 160;
  localparam int unsigned DEF_SCREEN_H = 120;
  localparam int unsigned DEF_BANNER_X0 = 40;
  localparam int unsigned DEF_BANNER_X1 = 119;
  localparam int unsigned DEF_BANNER_Y0 = 50;
  localparam int unsigned DEF_BANNER_Y1 = 69;

  localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
  localparam logic [COLOUR_W-1:0] RED   = 3'b100;
  localparam logic [COLOUR_W-1:0] GREEN = 3'b010;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    BANNER = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0]  x;
    logic [COORD_W-1:0]  y;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

endpackage

// File: rtl/raster_scan.sv
// Raster walker over an inclusive rectangle, x fastest.
// Ports: clk, rst_n (async, active-low); start reloads (X0,Y0);
// step advances one pixel, wrapping at (X1,Y1); x/y hold the current
// pixel; last is high while the current pixel is (X1,Y1).
module raster_scan
  import end_screen_draw_pkg::*;
#(
  parameter int unsigned X0 = 0,
  parameter int unsigned X1 = 0,
  parameter int unsigned Y0 = 0,
  parameter int unsigned Y1 = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               step,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last
);

  localparam logic [COORD_W-1:0] X0_C = COORD_W'(X0);
  localparam logic [COORD_W-1:0] X1_C = COORD_W'(X1);
  localparam logic [COORD_W-1:0] Y0_C = COORD_W'(Y0);
  localparam logic [COORD_W-1:0] Y1_C = COORD_W'(Y1);
  localparam logic SINGLE = (X0 == X1) && (Y0 == Y1);

  logic [COORD_W-1:0] nx;
  logic [COORD_W-1:0] ny;

  // Next raster position: column wraps to X0, row advances only at X1.
  always_comb begin
    nx = x;
    ny = y;
    if (x == X1_C) begin
      nx = X0_C;
      ny = (y == Y1_C) ? Y0_C : y + COORD_W'(1);
    end else begin
      nx = x + COORD_W'(1);
    end
  end

  // Position register; last is precomputed so it is valid with x/y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x    <= X0_C;
      y    <= Y0_C;
      last <= SINGLE;
    end else if (start) begin
      x    <= X0_C;
      y    <= Y0_C;
      last <= SINGLE;
    end else if (step) begin
      x    <= nx;
      y    <= ny;
      last <= (nx == X1_C) && (ny == Y1_C);
    end
  end

endmodule

// File: rtl/end_screen_draw.sv
// End screen painter: on a win or loss edge, clears the screen to black
// one pixel per cycle, then paints a banner (green on win, red on loss),
// then holds done.
// Ports: clk, resetn (async, active-low); win_in/loss_in result levels;
// x, y, colour, writeEn plot bus; win_draw/lose_draw mux selects; done.
module end_screen_draw
  import end_screen_draw_pkg::*;
#(
  parameter int unsigned SCREEN_W  = DEF_SCREEN_W,
  parameter int unsigned SCREEN_H  = DEF_SCREEN_H,
  parameter int unsigned BANNER_X0 = DEF_BANNER_X0,
  parameter int unsigned BANNER_X1 = DEF_BANNER_X1,
  parameter int unsigned BANNER_Y0 = DEF_BANNER_Y0,
  parameter int unsigned BANNER_Y1 = DEF_BANNER_Y1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                win_in,
  input  logic                loss_in,
  output logic [COORD_W-1:0]  x,
  output logic [COORD_W-1:0]  y,
  output logic [COLOUR_W-1:0] colour,
  output logic                writeEn,
  output logic                win_draw,
  output logic                lose_draw,
  output logic                done
);

  state_t state;
  state_t state_next;

  logic win_prev;
  logic loss_prev;
  logic win_edge;
  logic loss_edge;
  logic res_loss;

  logic               fill_start;
  logic               fill_step;
  logic [COORD_W-1:0] fill_x;
  logic [COORD_W-1:0] fill_y;
  logic               fill_last;

  logic               ban_start;
  logic               ban_step;
  logic [COORD_W-1:0] ban_x;
  logic [COORD_W-1:0] ban_y;
  logic               ban_last;

  pixel_t pix;

  // Previous levels reset to 0, so a level high at release is an edge.
  assign win_edge  = win_in & ~win_prev;
  assign loss_edge = loss_in & ~loss_prev;

  raster_scan #(
    .X0(0), .X1(SCREEN_W - 1), .Y0(0), .Y1(SCREEN_H - 1)
  ) u_fill_scan (
    .clk  (clk),
    .rst_n(resetn),
    .start(fill_start),
    .step (fill_step),
    .x    (fill_x),
    .y    (fill_y),
    .last (fill_last)
  );

  raster_scan #(
    .X0(BANNER_X0), .X1(BANNER_X1), .Y0(BANNER_Y0), .Y1(BANNER_Y1)
  ) u_banner_scan (
    .clk  (clk),
    .rst_n(resetn),
    .start(ban_start),
    .step (ban_step),
    .x    (ban_x),
    .y    (ban_y),
    .last (ban_last)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and scanner control; scanners sit at their origin until used.
  always_comb begin
    state_next = state;
    fill_start = 1'b0;
    fill_step  = 1'b0;
    ban_start  = 1'b0;
    ban_step   = 1'b0;
    unique case (state)
      IDLE: begin
        fill_start = 1'b1;
        ban_start  = 1'b1;
        if (win_edge || loss_edge) begin
          state_next = FILL;
        end
      end
      FILL: begin
        fill_step = 1'b1;
        ban_start = 1'b1;
        if (fill_last) begin
          state_next = BANNER;
        end
      end
      BANNER: begin
        ban_step = 1'b1;
        if (ban_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = DONE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Edge history and result latch; loss takes priority on a tie.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      win_prev  <= 1'b0;
      loss_prev <= 1'b0;
      res_loss  <= 1'b0;
    end else begin
      win_prev  <= win_in;
      loss_prev <= loss_in;
      if (state == IDLE && (win_edge || loss_edge)) begin
        res_loss <= loss_edge;
      end
    end
  end

  // Pixel payload for the current drawing state.
  always_comb begin
    pix = '{x: fill_x, y: fill_y, colour: BLACK};
    if (state == BANNER) begin
      pix = '{x: ban_x, y: ban_y, colour: (res_loss ? RED : GREEN)};
    end
  end

  // Registered plot bus and status; coordinates hold outside drawing states.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x         <= '0;
      y         <= '0;
      colour    <= '0;
      writeEn   <= 1'b0;
      win_draw  <= 1'b0;
      lose_draw <= 1'b0;
      done      <= 1'b0;
    end else begin
      writeEn   <= (state == FILL) || (state == BANNER);
      done      <= (state == DONE);
      win_draw  <= (state != IDLE) && !res_loss;
      lose_draw <= (state != IDLE) && res_loss;
      if (state == FILL || state == BANNER) begin
        x      <= pix.x;
        y      <= pix.y;
        colour <= pix.colour;
      end
    end
  end

endmodule
